// File: rtl/alu_exe_unit_pipe.sv
// rtl/alu_exe_unit_pipe.sv - pipelined integer ALU execution unit with branch-mask kill and per-stage bypass
//
// Ports:
//   clock, reset              single rising-edge clock, asynchronous active-high reset
//   io_flush                  kills every in-flight op and the incoming request
//   io_req_*                  issue request: fu_code filter, ALU fcn/width, tags, operands, kill
//   io_brupdate_*             branch resolve / mispredict masks for this cycle
//   io_resp_*                 result of the last pipeline stage
//   io_bypass_*               per-stage valid/pdst/rtype/data, stage i at slice i (0 = youngest)
module alu_exe_unit_pipe #(
    parameter int         XLEN       = 64,
    parameter int         BR_MASK_W  = 20,
    parameter int         ROB_IDX_W  = 7,
    parameter int         PDST_W     = 7,
    parameter int         NUM_STAGES = 3,
    parameter logic [9:0] FU_MASK    = 10'h023
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             io_flush,
    input  logic                             io_req_valid,
    input  logic [9:0]                       io_req_fu_code,
    input  logic [3:0]                       io_req_op_fcn,
    input  logic                             io_req_fcn_dw,
    input  logic [BR_MASK_W-1:0]             io_req_br_mask,
    input  logic [ROB_IDX_W-1:0]             io_req_rob_idx,
    input  logic [PDST_W-1:0]                io_req_pdst,
    input  logic [1:0]                       io_req_dst_rtype,
    input  logic [XLEN:0]                    io_req_rs1_data,
    input  logic [XLEN:0]                    io_req_rs2_data,
    input  logic                             io_req_kill,
    input  logic [BR_MASK_W-1:0]             io_brupdate_resolve_mask,
    input  logic [BR_MASK_W-1:0]             io_brupdate_mispredict_mask,
    output logic                             io_resp_valid,
    output logic [ROB_IDX_W-1:0]             io_resp_rob_idx,
    output logic [PDST_W-1:0]                io_resp_pdst,
    output logic [1:0]                       io_resp_dst_rtype,
    output logic [BR_MASK_W-1:0]             io_resp_br_mask,
    output logic [XLEN:0]                    io_resp_data,
    output logic [NUM_STAGES-1:0]            io_bypass_valid,
    output logic [NUM_STAGES*PDST_W-1:0]     io_bypass_pdst,
    output logic [NUM_STAGES*2-1:0]          io_bypass_dst_rtype,
    output logic [NUM_STAGES*(XLEN+1)-1:0]   io_bypass_data
);

    localparam int SHW  = $clog2(XLEN);
    localparam int LAST = NUM_STAGES - 1;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SL   = 4'd1;
    localparam logic [3:0] FN_SEQ  = 4'd2;
    localparam logic [3:0] FN_SNE  = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_SR   = 4'd5;
    localparam logic [3:0] FN_OR   = 4'd6;
    localparam logic [3:0] FN_AND  = 4'd7;
    localparam logic [3:0] FN_SUB  = 4'd10;
    localparam logic [3:0] FN_SRA  = 4'd11;
    localparam logic [3:0] FN_SLT  = 4'd12;
    localparam logic [3:0] FN_SGE  = 4'd13;
    localparam logic [3:0] FN_SLTU = 4'd14;
    localparam logic [3:0] FN_SGEU = 4'd15;

    // ---------------- ALU (combinational in the request cycle) ----------------
    logic [XLEN-1:0] op_a, op_b, raw, alu_result;
    logic [31:0]     sl32, sr32, sra32;
    logic            is_cmp;
    logic            unused_tag_bits;

    // Operand tag bits carry no information for integer ops.
    assign unused_tag_bits = ^{io_req_rs1_data[XLEN], io_req_rs2_data[XLEN]};

    always_comb begin
        op_a   = io_req_rs1_data[XLEN-1:0];
        op_b   = io_req_rs2_data[XLEN-1:0];
        sl32   = op_a[31:0] << op_b[4:0];
        sr32   = op_a[31:0] >> op_b[4:0];
        sra32  = $unsigned($signed(op_a[31:0]) >>> op_b[4:0]);
        is_cmp = 1'b0;
        raw    = '0;
        case (io_req_op_fcn)
            FN_ADD:  raw = op_a + op_b;
            FN_SUB:  raw = op_a - op_b;
            FN_XOR:  raw = op_a ^ op_b;
            FN_OR:   raw = op_a | op_b;
            FN_AND:  raw = op_a & op_b;
            // 32-bit shifts work on the low word only so no upper bits leak in
            FN_SL:   raw = io_req_fcn_dw ? op_a << op_b[SHW-1:0] : XLEN'(sl32);
            FN_SR:   raw = io_req_fcn_dw ? op_a >> op_b[SHW-1:0] : XLEN'(sr32);
            FN_SRA:  raw = io_req_fcn_dw ? $unsigned($signed(op_a) >>> op_b[SHW-1:0]) : XLEN'(sra32);
            FN_SEQ:  begin is_cmp = 1'b1; raw = XLEN'(op_a == op_b); end
            FN_SNE:  begin is_cmp = 1'b1; raw = XLEN'(op_a != op_b); end
            FN_SLT:  begin is_cmp = 1'b1; raw = XLEN'($signed(op_a) <  $signed(op_b)); end
            FN_SGE:  begin is_cmp = 1'b1; raw = XLEN'($signed(op_a) >= $signed(op_b)); end
            FN_SLTU: begin is_cmp = 1'b1; raw = XLEN'(op_a <  op_b); end
            FN_SGEU: begin is_cmp = 1'b1; raw = XLEN'(op_a >= op_b); end
            default: raw = '0;
        endcase
        // Compares are always full width; other 32-bit ops sign-extend the low word.
        alu_result = (is_cmp || io_req_fcn_dw) ? raw : {{(XLEN-32){raw[31]}}, raw[31:0]};
    end

    // ---------------- Request filter ----------------
    logic accept;
    assign accept = io_req_valid & (|(io_req_fu_code & FU_MASK)) & ~io_req_kill & ~io_flush
                  & ~(|(io_req_br_mask & io_brupdate_mispredict_mask));

    // ---------------- Result pipeline ----------------
    logic                 stg_valid   [NUM_STAGES];
    logic [XLEN-1:0]      stg_data    [NUM_STAGES];
    logic [ROB_IDX_W-1:0] stg_rob_idx [NUM_STAGES];
    logic [PDST_W-1:0]    stg_pdst    [NUM_STAGES];
    logic [1:0]           stg_rtype   [NUM_STAGES];
    logic [BR_MASK_W-1:0] stg_br_mask [NUM_STAGES];

    // Kill happens on the transfer: a stage still shows its pre-kill valid in the
    // mispredict/flush cycle, and the op is gone from the next stage onward.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) stg_valid[i] <= 1'b0;
        end else begin
            stg_valid[0] <= accept;
            for (int i = 1; i < NUM_STAGES; i++)
                stg_valid[i] <= stg_valid[i-1] & ~io_flush
                              & ~(|(stg_br_mask[i-1] & io_brupdate_mispredict_mask));
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clock) begin
        stg_data[0]    <= alu_result;
        stg_rob_idx[0] <= io_req_rob_idx;
        stg_pdst[0]    <= io_req_pdst;
        stg_rtype[0]   <= io_req_dst_rtype;
        stg_br_mask[0] <= io_req_br_mask & ~io_brupdate_resolve_mask;
        for (int i = 1; i < NUM_STAGES; i++) begin
            stg_data[i]    <= stg_data[i-1];
            stg_rob_idx[i] <= stg_rob_idx[i-1];
            stg_pdst[i]    <= stg_pdst[i-1];
            stg_rtype[i]   <= stg_rtype[i-1];
            stg_br_mask[i] <= stg_br_mask[i-1] & ~io_brupdate_resolve_mask;
        end
    end

    // ---------------- Outputs (zero while the stage is invalid) ----------------
    always_comb begin
        io_resp_valid     = stg_valid[LAST];
        io_resp_rob_idx   = stg_valid[LAST] ? stg_rob_idx[LAST] : '0;
        io_resp_pdst      = stg_valid[LAST] ? stg_pdst[LAST]    : '0;
        io_resp_dst_rtype = stg_valid[LAST] ? stg_rtype[LAST]   : '0;
        io_resp_br_mask   = stg_valid[LAST] ? stg_br_mask[LAST] : '0;
        io_resp_data      = stg_valid[LAST] ? {1'b0, stg_data[LAST]} : '0;
    end

    always_comb begin
        io_bypass_valid     = '0;
        io_bypass_pdst      = '0;
        io_bypass_dst_rtype = '0;
        io_bypass_data      = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            io_bypass_valid[i] = stg_valid[i];
            if (stg_valid[i]) begin
                io_bypass_pdst[i*PDST_W +: PDST_W]     = stg_pdst[i];
                io_bypass_dst_rtype[i*2 +: 2]          = stg_rtype[i];
                io_bypass_data[i*(XLEN+1) +: XLEN+1]   = {1'b0, stg_data[i]};
            end
        end
    end

endmodule
